// File: rtl/framemem_wr_ctrl.sv
// Frame-memory write controller: gathers a raster pixel stream into 2x2 pixel
// blocks and writes each completed block as one 96-bit word.
module framemem_wr_ctrl #(
    parameter int HRES       = 320,
    parameter int VRES       = 240,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  SOF,
    input  logic                  PIX_VLD,
    input  logic [23:0]           PIX_DATA,
    output logic                  PIX_RDY,
    output logic                  MEM_CSN,
    output logic                  MEM_WEN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [95:0]           MEM_DIN,
    output logic                  FRAME_DONE,
    output logic                  SOF_ERR
);

    localparam int CW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int RW = (VRES > 1) ? $clog2(VRES) : 1;
    localparam int IW = (HRES > 2) ? $clog2(HRES / 2) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(HRES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(VRES - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [ADDR_WIDTH-1:0]   blk_addr;
    logic [23:0]             odd_pix;
    logic [47:0]             line_buf [HRES/2];

    logic                    accept;
    logic                    at_last;
    logic                    restart;
    logic                    take;
    logic                    blk_done;
    logic [CW-1:0]           pcol;
    logic [RW-1:0]           prow;
    logic [IW-1:0]           pidx;

    // A restarting SOF relocates the current pixel to (0,0) before it is stored.
    always_comb begin
        accept   = PIX_VLD & PIX_RDY;
        at_last  = (state == ACTIVE) && (row == ROW_LAST) && (col == COL_LAST);
        restart  = accept & SOF & ~at_last;
        take     = accept & ((state == ACTIVE) | SOF);
        pcol     = restart ? '0 : col;
        prow     = restart ? '0 : row;
        pidx     = IW'(pcol >> 1);
        blk_done = take & prow[0] & pcol[0];
    end

    // NOTE: the line buffer is plain storage; it is always rewritten before it is
    // read, so it carries no reset and can map onto RAM.
    always_ff @(posedge CLK) begin
        if (take && !prow[0]) begin
            if (pcol[0]) line_buf[pidx][23:0]  <= PIX_DATA;
            else         line_buf[pidx][47:24] <= PIX_DATA;
        end
    end

    // NOTE: all state below is registered with non-blocking assignments so every
    // read in this block sees the pre-edge value.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            blk_addr   <= '0;
            odd_pix    <= '0;
            PIX_RDY    <= 1'b0;
            MEM_CSN    <= 1'b1;
            MEM_WEN    <= 1'b1;
            MEM_ADDR   <= '0;
            MEM_DIN    <= '0;
            FRAME_DONE <= 1'b0;
            SOF_ERR    <= 1'b0;
        end else begin
            PIX_RDY    <= 1'b1;
            MEM_CSN    <= 1'b1;
            MEM_WEN    <= 1'b1;
            FRAME_DONE <= 1'b0;
            SOF_ERR    <= 1'b0;
            if (take) begin
                state <= at_last ? IDLE : ACTIVE;
                if (restart) blk_addr <= '0;
                if (restart && state == ACTIVE) SOF_ERR <= 1'b1;
                if (pcol == COL_LAST) begin
                    col <= '0;
                    row <= (prow == ROW_LAST) ? '0 : prow + RW'(1);
                end else begin
                    col <= pcol + CW'(1);
                    row <= prow;
                end
                if (prow[0] && !pcol[0]) odd_pix <= PIX_DATA;
                // Blocks complete in address order, so a running count is the address.
                if (blk_done) begin
                    MEM_CSN    <= 1'b0;
                    MEM_WEN    <= 1'b0;
                    MEM_ADDR   <= blk_addr;
                    MEM_DIN    <= {line_buf[pidx], odd_pix, PIX_DATA};
                    blk_addr   <= blk_addr + ADDR_WIDTH'(1);
                    FRAME_DONE <= at_last;
                end
            end
        end
    end

endmodule
